// File: rtl/cordic_pkg.sv
// Shared CORDIC constants for the rotation and vectoring datapaths.
//   atan_lut(i)  : round(atan(2^-i) * 2^32 / (2*pi)), full turn = 2^32
//   K_INV        : 1/K gain compensation, 0.607253 * 2^K_INV_SHIFT
//   PHASE_HALF   : 180 degrees on the 32-bit phase scale
//   CORDIC_FRAC  : fractional bits carried below the input LSB in x/y
package cordic_pkg;

  localparam logic [31:0]  PHASE_HALF  = 32'h8000_0000;
  localparam logic [16:0]  K_INV       = 17'd79594;
  localparam int unsigned  K_INV_SHIFT = 17;

  // Without sub-LSB bits the late micro-rotations see x>>>i == 0 for small
  // vectors and y sticks at -1, walking the phase far off; 22 bits keeps the
  // truncation error well below the last atan step even for |v| ~ 1.
  localparam int unsigned  CORDIC_FRAC = 22;

  function automatic logic [31:0] atan_lut(input int unsigned i);
    case (i)
      0:  atan_lut = 32'd536870912;
      1:  atan_lut = 32'd316933406;
      2:  atan_lut = 32'd167458907;
      3:  atan_lut = 32'd85004756;
      4:  atan_lut = 32'd42667331;
      5:  atan_lut = 32'd21354465;
      6:  atan_lut = 32'd10679838;
      7:  atan_lut = 32'd5340245;
      8:  atan_lut = 32'd2670163;
      9:  atan_lut = 32'd1335087;
      10: atan_lut = 32'd667544;
      11: atan_lut = 32'd333772;
      12: atan_lut = 32'd166886;
      13: atan_lut = 32'd83443;
      14: atan_lut = 32'd41722;
      15: atan_lut = 32'd20861;
      16: atan_lut = 32'd10430;
      17: atan_lut = 32'd5215;
      18: atan_lut = 32'd2608;
      19: atan_lut = 32'd1304;
      20: atan_lut = 32'd652;
      21: atan_lut = 32'd326;
      22: atan_lut = 32'd163;
      23: atan_lut = 32'd81;
      24: atan_lut = 32'd41;
      25: atan_lut = 32'd20;
      26: atan_lut = 32'd10;
      27: atan_lut = 32'd5;
      28: atan_lut = 32'd3;
      29: atan_lut = 32'd1;
      30: atan_lut = 32'd1;
      default: atan_lut = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation.
//   clock, reset_n       : clock, async active-low reset
//   in_valid/in_zero     : slot valid and exact-zero flag, passed through
//   in_x/in_y/in_z       : vector (signed W) and accumulated phase
//   out_*                : same fields, one clock later
// Rotation direction drives y toward zero; z accumulates the applied angle.
module cordic_vec_stage #(
  parameter int unsigned     W        = 44,
  parameter int unsigned     PW       = 32,
  parameter int unsigned     SHIFT    = 0,
  parameter logic [PW-1:0]   ATAN_VAL = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          in_zero,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  input  logic [PW-1:0] in_z,
  output logic          out_valid,
  output logic          out_zero,
  output logic [W-1:0]  out_x,
  output logic [W-1:0]  out_y,
  output logic [PW-1:0] out_z
);

  logic signed [W-1:0] xs, ys, x_sh, y_sh;

  always_comb begin
    xs   = $signed(in_x);
    ys   = $signed(in_y);
    x_sh = xs >>> SHIFT;
    y_sh = ys >>> SHIFT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      out_valid <= in_valid;
      out_zero  <= in_zero;
      if (ys[W-1]) begin
        // y below axis: rotate counter-clockwise
        out_x <= xs - y_sh;
        out_y <= ys + x_sh;
        out_z <= in_z - ATAN_VAL;
      end else begin
        out_x <= xs + y_sh;
        out_y <= ys - x_sh;
        out_z <= in_z + ATAN_VAL;
      end
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Pipelined vectoring CORDIC: (re, im) -> (magnitude, phase).
//   clock, reset_n      : clock, async active-low reset
//   in_valid            : qualifies in_re/in_im
//   in_re, in_im        : signed IN_WIDTH samples
//   out_valid           : qualifies out_mag/out_phase, in_valid delayed STAGES+2
//   out_mag             : unsigned gain-compensated magnitude, saturating
//   out_phase           : atan2(im,re), full turn = 2^PHASE_WIDTH
module cordic_vector import cordic_pkg::*; #(
  parameter int unsigned IN_WIDTH    = 20,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned STAGES      = 18,
  parameter int unsigned GUARD       = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [IN_WIDTH-1:0]    in_re,
  input  logic [IN_WIDTH-1:0]    in_im,
  output logic                   out_valid,
  output logic [IN_WIDTH:0]      out_mag,
  output logic [PHASE_WIDTH-1:0] out_phase
);

  localparam int unsigned W         = IN_WIDTH + GUARD + CORDIC_FRAC;
  localparam int unsigned PROD_W    = W + 18;
  localparam int unsigned MAG_SHIFT = K_INV_SHIFT + CORDIC_FRAC;
  localparam logic [PHASE_WIDTH-1:0] Z_HALF =
    PHASE_WIDTH'(PHASE_HALF >> (32 - PHASE_WIDTH));

  logic [STAGES:0][W-1:0]           sx, sy;
  logic [STAGES:0][PHASE_WIDTH-1:0] sz;
  logic [STAGES:0]                  sv, s0;

  // Pre-rotation: fold left half-plane into right half-plane (+180 deg)
  logic [W-1:0]           re_ext, im_ext;
  logic [W-1:0]           p_x, p_y;
  logic [PHASE_WIDTH-1:0] p_z;
  logic                   p_v, p_zero;

  assign re_ext = {{GUARD{in_re[IN_WIDTH-1]}}, in_re, {CORDIC_FRAC{1'b0}}};
  assign im_ext = {{GUARD{in_im[IN_WIDTH-1]}}, in_im, {CORDIC_FRAC{1'b0}}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_v    <= 1'b0;
      p_zero <= 1'b0;
      p_x    <= '0;
      p_y    <= '0;
      p_z    <= '0;
    end else begin
      p_v    <= in_valid;
      p_zero <= (in_re == '0) && (in_im == '0);
      if (in_re[IN_WIDTH-1]) begin
        p_x <= -re_ext;
        p_y <= -im_ext;
        p_z <= Z_HALF;
      end else begin
        p_x <= re_ext;
        p_y <= im_ext;
        p_z <= '0;
      end
    end
  end

  assign sx[0] = p_x;
  assign sy[0] = p_y;
  assign sz[0] = p_z;
  assign sv[0] = p_v;
  assign s0[0] = p_zero;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_vec_stage #(
      .W        (W),
      .PW       (PHASE_WIDTH),
      .SHIFT    (i),
      .ATAN_VAL (PHASE_WIDTH'(atan_lut(i) >> (32 - PHASE_WIDTH)))
    ) u_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (sv[i]),
      .in_zero   (s0[i]),
      .in_x      (sx[i]),
      .in_y      (sy[i]),
      .in_z      (sz[i]),
      .out_valid (sv[i+1]),
      .out_zero  (s0[i+1]),
      .out_x     (sx[i+1]),
      .out_y     (sy[i+1]),
      .out_z     (sz[i+1])
    );
  end

  // Residual y of the last stage carries no information
  logic unused_y;
  assign unused_y = ^sy[STAGES];

  // Gain compensation: round half-up, clamp negative to 0, saturate high
  logic signed [PROD_W-1:0] prod, rounded, scaled;
  logic [IN_WIDTH:0]        mag_next;

  assign prod    = PROD_W'($signed(sx[STAGES])) * PROD_W'($signed({1'b0, K_INV}));
  assign rounded = prod + (PROD_W'(1) << (MAG_SHIFT - 1));
  assign scaled  = rounded >>> MAG_SHIFT;

  always_comb begin
    mag_next = scaled[IN_WIDTH:0];
    if (scaled[PROD_W-1])
      mag_next = '0;
    else if (|scaled[PROD_W-2:IN_WIDTH+1])
      mag_next = '1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_phase <= '0;
    end else begin
      out_valid <= sv[STAGES];
      if (s0[STAGES]) begin
        out_mag   <= '0;
        out_phase <= '0;
      end else begin
        out_mag   <= mag_next;
        out_phase <= sz[STAGES];
      end
    end
  end

endmodule
